// File: rtl/serial_mul3_ctrl.sv
// rtl/serial_mul3_ctrl.sv - sequencing controller for the bit-serial multiply-by-3 core
module serial_mul3_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   operand,
  input  logic               abort,
  output logic               ser_bit,
  output logic               ser_clr,
  input  logic               ser_res,
  output logic               busy,
  output logic               done,
  output logic [WIDTH+1:0]   result
);

  localparam int RW = WIDTH + 2;
  localparam int IW = $clog2(RW);
  localparam logic [IW-1:0] IDX_LAST = IW'(RW - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_SHIFT = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          state;
  logic [RW-1:0]   opreg;
  logic [IW-1:0]   idx;
  logic [IW-1:0]   idx_nxt;
  // sreg collects the first RW-1 result bits; the last one goes straight into result.
  logic [RW-2:0]   sreg;

  assign idx_nxt = idx + 1'b1;

  // Outputs are registered with the value belonging to the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      opreg   <= '0;
      idx     <= '0;
      sreg    <= '0;
      result  <= '0;
      ser_bit <= 1'b0;
      ser_clr <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          ser_bit <= 1'b0;
          done    <= 1'b0;
          if (start) begin
            state   <= S_CLR;
            opreg   <= {2'b00, operand};
            idx     <= '0;
            sreg    <= '0;
            ser_clr <= 1'b1;
            busy    <= 1'b1;
          end else begin
            ser_clr <= 1'b0;
            busy    <= 1'b0;
          end
        end

        S_CLR: begin
          ser_clr <= 1'b0;
          if (abort) begin
            state   <= S_IDLE;
            ser_bit <= 1'b0;
            busy    <= 1'b0;
            sreg    <= '0;
          end else begin
            state   <= S_SHIFT;
            ser_bit <= opreg[0];
          end
        end

        S_SHIFT: begin
          if (abort) begin
            state   <= S_IDLE;
            ser_bit <= 1'b0;
            busy    <= 1'b0;
            sreg    <= '0;
          end else begin
            // ser_res lags ser_bit by one cycle, so nothing is captured at idx 0.
            if (idx != '0) begin
              sreg <= {ser_res, sreg[RW-2:1]};
            end
            if (idx == IDX_LAST) begin
              state   <= S_DRAIN;
              ser_bit <= 1'b0;
            end else begin
              idx     <= idx_nxt;
              ser_bit <= opreg[idx_nxt];
            end
          end
        end

        S_DRAIN: begin
          if (abort) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            sreg  <= '0;
          end else begin
            state  <= S_DONE;
            result <= {ser_res, sreg};
            done   <= 1'b1;
          end
        end

        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end

        default: begin
          state   <= S_IDLE;
          ser_bit <= 1'b0;
          ser_clr <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_mul3_ctrl.sv
// tb/tb_serial_mul3_ctrl.sv - self-checking bench for serial_mul3_ctrl with a serial x3 core model
module tb_serial_mul3_ctrl;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] operand;
  logic       abort;
  logic       ser_bit;
  logic       ser_clr;
  logic       ser_res;
  logic       busy;
  logic       done;
  logic [9:0] result;

  int total = 0;
  int bad = 0;
  logic [9:0] last_result;

  serial_mul3_ctrl #(.WIDTH(8)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .operand(operand),
    .abort(abort),
    .ser_bit(ser_bit),
    .ser_clr(ser_clr),
    .ser_res(ser_res),
    .busy(busy),
    .done(done),
    .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Serial x3 core: y = x + 2x, LSB first, registered output, cleared by ser_clr.
  logic core_prev;
  logic core_carry;
  always @(posedge clk) begin
    int s;
    if (reset || ser_clr) begin
      core_prev  <= 1'b0;
      core_carry <= 1'b0;
      ser_res    <= 1'b0;
    end else begin
      s = int'(ser_bit) + int'(core_prev) + int'(core_carry);
      ser_res    <= s[0];
      core_carry <= s[1];
      core_prev  <= ser_bit;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_step();
    @(posedge clk); #1;
    abort = 1'b0;
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
    chk("idle_clr", ser_clr, 0);
    chk("idle_result", result, last_result);
  endtask

  // Called in the cycle where start is sampled (cycle 0); returns at cycle 13.
  task automatic run_op(input logic [7:0] op, input int abort_at, input int reset_at,
                        input bit hold, input bit abort_c0);
    logic [9:0] opx;
    logic [9:0] expv;
    bit killed;
    int kill_at;
    opx    = {2'b00, op};
    expv   = 10'(int'(op) * 3);
    killed = (abort_at > 0 && abort_at < 13) || reset_at > 0;
    kill_at = (reset_at > 0) ? reset_at : abort_at;
    start   = 1'b1;
    operand = op;
    abort   = abort_c0;
    for (int c = 1; c <= 13; c++) begin
      @(posedge clk); #1;
      abort = 1'b0;
      reset = 1'b0;
      if (!hold) start = 1'b0;
      if (killed && c > kill_at) begin
        if (c == kill_at + 1) begin
          if (reset_at > 0) last_result = '0;
          chk("kill_busy", busy, 0);
          chk("kill_clr", ser_clr, 0);
          chk("kill_bit", ser_bit, 0);
          chk("kill_result", result, last_result);
        end
        chk("kill_done", done, 0);
      end else begin
        chk($sformatf("busy_c%0d", c), busy, 1);
        chk($sformatf("clr_c%0d", c), ser_clr, (c == 1) ? 1 : 0);
        chk($sformatf("done_c%0d", c), done, (c == 13) ? 1 : 0);
        chk($sformatf("bit_c%0d", c), ser_bit, (c >= 2 && c <= 11) ? 32'(opx[c-2]) : 0);
        if (c == 13) begin
          chk($sformatf("result_op%0h", op), result, expv);
          last_result = expv;
        end else begin
          chk($sformatf("held_c%0d", c), result, last_result);
        end
      end
      if (c == abort_at) abort = 1'b1;
      if (c == reset_at) reset = 1'b1;
    end
    start = hold;
    abort = 1'b0;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    operand = '0;
    last_result = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_bit", ser_bit, 0);
    chk("rst_clr", ser_clr, 0);
    reset = 1'b0;
    idle_step();

    run_op(8'h05, 0, 0, 0, 0); idle_step();
    run_op(8'hFF, 0, 0, 0, 0); idle_step();
    run_op(8'h00, 0, 0, 0, 0); idle_step();

    // start held high: back-to-back products, pulses during busy ignored
    run_op(8'h80, 0, 0, 1, 0);
    operand = 8'h01;
    idle_step();
    run_op(8'h01, 0, 0, 0, 0); idle_step();

    // abort mid-shift after a completed run
    run_op(8'h05, 0, 0, 0, 0); idle_step();
    run_op(8'hAA, 6, 0, 0, 0); idle_step();
    chk("abort_keep", result, 10'h00F);
    run_op(8'h03, 0, 0, 0, 0); idle_step();

    // synchronous reset mid-run
    run_op(8'h77, 0, 8, 0, 0); idle_step();
    run_op(8'h10, 0, 0, 0, 0); idle_step();

    // start and abort together in IDLE, then abort during DONE
    run_op(8'h55, 0, 0, 0, 1); idle_step();
    run_op(8'h21, 13, 0, 0, 0); idle_step();

    for (int i = 0; i < 8; i++) begin
      run_op(8'($urandom_range(0, 255)), 0, 0, 0, 0);
      idle_step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
